// File: rtl/pal_pkg.sv
// Shared definitions for the PAL programming blocks: loader FSM states and
// the default OR-array geometry.
package pal_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PARITY = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } pal_state_e;

  // Default OR-array geometry: product-term inputs per row, number of rows.
  localparam int PAL_NUM_INPUTS = 5;
  localparam int PAL_SIZE       = 5;

endpackage : pal_pkg

// File: rtl/pal_fuse_loader.sv
// Serial fuse loader for the PAL OR array. Shifts SIZE*NUM_INPUTS data bits
// plus one even-parity bit into a shadow register, then pulses wen for one
// cycle when the parity checks out. The shadow register drives sel directly.
module pal_fuse_loader
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS = PAL_NUM_INPUTS,
  parameter int SIZE       = PAL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_ready,
  output logic [NUM_INPUTS-1:0] sel [SIZE-1:0],
  output logic                  wen,
  output logic                  done,
  output logic                  err
);

  localparam int TOTAL = SIZE * NUM_INPUTS;
  // One extra code point so the counter can represent TOTAL itself.
  localparam int CNT_W = $clog2(TOTAL + 1);

  pal_state_e r_state;
  pal_state_e w_state_next;

  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_parity;
  logic [NUM_INPUTS-1:0] r_sel      [SIZE-1:0];
  logic [NUM_INPUTS-1:0] w_sel_next [SIZE-1:0];
  logic                  r_cfg_ready;
  logic                  r_wen;
  logic                  r_done;
  logic                  r_err;

  logic             w_restart;
  logic             w_xfer;
  logic             w_load_xfer;
  logic             w_last_bit;
  logic [TOTAL-1:0] w_cell_we;

  // A start request restarts the load from anywhere except COMMIT, where the
  // write to the OR array is already under way.
  assign w_restart   = cfg_start && (r_state != ST_COMMIT);
  // The bit offered alongside a restart is discarded, hence the !cfg_start.
  assign w_xfer      = cfg_valid && r_cfg_ready && !cfg_start;
  assign w_load_xfer = w_xfer && (r_state == ST_LOAD);
  assign w_last_bit  = (r_bit_cnt == CNT_W'(TOTAL - 1));

  // One write enable per fuse cell: cell k captures the k-th accepted bit.
  generate
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_cell_we
      assign w_cell_we[gi] = w_load_xfer && (r_bit_cnt == CNT_W'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cfg_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (cfg_start) begin
          w_state_next = ST_LOAD;
        end else if (w_xfer && w_last_bit) begin
          w_state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (cfg_start) begin
          w_state_next = ST_LOAD;
        end else if (w_xfer) begin
          // Even parity over data plus parity bit must come out zero.
          w_state_next = (r_parity ^ cfg_bit) ? ST_ERROR : ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bit counter and running parity of the accepted data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_restart) begin
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_load_xfer) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      r_parity  <= r_parity ^ cfg_bit;
    end
  end

  // Shadow register update: clear on restart, otherwise write the addressed cell.
  always_comb begin
    w_sel_next = r_sel;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        if (w_restart) begin
          w_sel_next[r][c] = 1'b0;
        end else if (w_cell_we[r*NUM_INPUTS + c]) begin
          w_sel_next[r][c] = cfg_bit;
        end
      end
    end
  end

  // Shadow register; it is never written outside LOAD, so it holds through COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SIZE; r++) begin
        r_sel[r] <= '0;
      end
    end else begin
      r_sel <= w_sel_next;
    end
  end

  // Registered status outputs, decoded from the state being entered so that
  // each one lines up exactly with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_ready <= 1'b0;
      r_wen       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cfg_ready <= (w_state_next == ST_LOAD) || (w_state_next == ST_PARITY);
      r_wen       <= (w_state_next == ST_COMMIT);
      r_done      <= (w_state_next == ST_DONE);
      r_err       <= (w_state_next == ST_ERROR);
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign wen       = r_wen;
  assign done      = r_done;
  assign err       = r_err;
  assign sel       = r_sel;

endmodule : pal_fuse_loader
